display_scan_driver: RTL and testbench
======================================

Name: display_scan_driver

Overview:
- Parametrised successor to the single-width multiplexed 7-segment display driver.
- Drives NUM_DIGITS common-anode digits through a time-multiplexed scan.
- Adds a frame-consistent value snapshot, per-digit decimal points, leading-zero blanking, inter-digit dead time (anti-ghosting) and 4-bit PWM brightness.
- Sits between the stopwatch/counter datapath and the board's select and segment pins.

Parameters:
NUM_DIGITS, 4, digits scanned; legal range 1..8
REFRESH_DIV, 125000, clk cycles per digit slot; must be >= DEAD_CYCLES+16
DEAD_CYCLES, 8, cycles at the start of each slot with all selects off

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
enable  in  1  1 = scan; 0 = blank all outputs and freeze counters
number  in  NUM_DIGITS*4  hex nybbles; digit i = number[4i+3:4i]; digit 0 is least significant
dp  in  NUM_DIGITS  decimal-point request per digit, active-high
blank_lz  in  1  1 = suppress leading zeros
brightness  in  4  0 = dimmest, 15 = full
io_sel  out  NUM_DIGITS  digit selects, active-low, registered
io_seg  out  8  segments {dp,g..a}, active-low, registered
frame_tick  out  1  one-cycle pulse when a new snapshot is captured

Behaviour:
- Reset (rst low, async):
  - prescaler, digit index, snapshot, brightness latch and frame_tick are all 0.
  - io_sel and io_seg are all 1s.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. The wrap cycle is the slot tick.
- On each slot tick:
  - Digit index advances and wraps NUM_DIGITS-1 -> 0.
  - brightness is latched for the next slot.
- When the index wraps to 0 on a tick:
  - number, dp and blank_lz are captured into the snapshot.
  - frame_tick pulses 1 in the following cycle.
- All display decisions use only the snapshot and the brightness latch. Input changes mid-frame never tear the display.
- Slot timing, with c = prescaler value in the current slot:
  - DEAD_CYCLES <= c < DEAD_CYCLES+on_len: the digit is lit.
  - Any other c: all selects are 1.
  - on_len = ((REFRESH_DIV-DEAD_CYCLES)*(b+1))>>4, where b is the latched brightness.
  - on_len is computed with constant-width arithmetic, at least clog2(REFRESH_DIV)+5 bits.
- When lit:
  - io_sel bit index is 0; all other bits are 1.
  - io_seg[6:0] is the active-low hex pattern (0-F) for the selected nybble.
  - io_seg[7] = ~dp_snapshot[index].
- Leading-zero blanking (blank_lz snapshot = 1):
  - Digit i is blanked (io_seg[6:0] = 7'h7F) when every nybble at positions >= i is 0 and i != 0.
  - Digit 0 is never blanked.
  - The dp is still driven for blanked digits. A blanked digit's select is still asserted during its lit window.
- Output latency: io_sel and io_seg are registered, one cycle after the prescaler/index state that produces them.
- enable = 0:
  - Next cycle io_sel and io_seg are all 1s.
  - Prescaler, index and snapshot hold.
  - enable returning to 1 resumes from the held state.
- Reset mid-slot: all outputs are 1s immediately (async). The scan restarts at digit 0, prescaler 0, and shows the zero snapshot until the first wrap.
- NUM_DIGITS = 1: the index stays 0 and every tick is also a frame tick.

Decomposition:
- Shared package holds:
  - the segment-pattern constants for hex 0-F;
  - the blank pattern constant 8'hFF;
  - the clog2 helper function.
- One sub-module: seven_seg_hex.
  - Purely combinational 4-bit to 7-bit active-low decoder.
  - Instanced once on the selected nybble.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=32, DEAD_CYCLES=2):
1. number=16'h1234, dp=0, blank_lz=0, brightness=15 -> after the first frame_tick:
   - io_sel cycles 1110,1101,1011,0111, with 32-cycle slots;
   - each slot is lit for 30 cycles, after 2 cycles of 1111;
   - io_seg shows 4,3,2,1 (8'h99, 8'hB0, 8'hA4, 8'hF9).
2. brightness=7 -> lit window is 15 cycles per slot. brightness=0 -> lit window is 1 cycle. A brightness change mid-slot takes effect only at the next slot.
3. number=16'h0050, blank_lz=1:
   - digits 3 and 2 show 8'hFF;
   - digit 1 shows 5 (8'h92);
   - digit 0 shows 0 (8'hC0).
   number=0 with blank_lz=1 -> only digit 0 shows 8'hC0.
4. number changes from 16'h1111 to 16'h2222 during digit 1's slot -> digits 2 and 3 still show 1. All digits show 2 only after the next frame_tick.
5. dp=4'b0100 -> io_seg[7]=0 only while io_sel=1011.
6. Two resets:
   - rst low at a mid-slot cycle -> io_sel=1111 and io_seg=8'hFF asynchronously; after release the scan restarts at digit 0.
   - enable=0 for 10 cycles -> outputs are all 1s and the prescaler value is unchanged on resume.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// Shared constants for the multiplexed display driver: active-low hex segment
// patterns, the all-off pattern and a constant-safe clog2.
package display_scan_driver_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry k is the glyph for hex digit k.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'(1) << r) < 64'(value)) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/display_scan_driver_seven_seg_hex.sv
// Hex nybble to active-low 7-segment glyph; purely combinational, zero latency,
// no flow control.
module seven_seg_hex
    import display_scan_driver_pkg::*;
(
    input  logic [3:0] nyb,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nyb];

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed common-anode scan with frame snapshot, dead time and PWM brightness.
// Outputs registered one cycle after the scan state; enable=0 blanks and freezes (no backpressure).
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 125000,
    parameter int DEAD_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_DIGITS*4-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   io_sel,
    output logic [7:0]              io_seg,
    output logic                    frame_tick
);

    localparam int PW = clog2(REFRESH_DIV);
    localparam int IW = clog2(NUM_DIGITS);
    localparam int OW = PW + 5;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [OW-1:0] DEAD_W     = OW'(DEAD_CYCLES);
    localparam logic [OW-1:0] SPAN_W     = OW'(REFRESH_DIV - DEAD_CYCLES);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [3:0]              bright_q;
    logic [NUM_DIGITS*4-1:0] snap_num;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_lz;

    logic                    slot_tick;
    logic                    frame_wrap;
    logic [3:0]              nyb;
    logic                    dp_bit;
    logic                    upper_nz;
    logic                    blank_digit;
    logic [6:0]              hex_seg;
    logic [OW-1:0]           presc_w;
    logic [OW-1:0]           on_len;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   sel_on;
    logic [7:0]              seg_on;

    assign slot_tick  = (presc == PRESC_LAST);
    assign frame_wrap = slot_tick && (idx == IDX_LAST);

    // Digit mux plus "any non-zero nybble at or above this position" for zero blanking.
    always_comb begin
        nyb      = 4'h0;
        dp_bit   = 1'b0;
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx == IW'(j)) begin
                nyb    = snap_num[4*j +: 4];
                dp_bit = snap_dp[j];
            end
            if ((IW'(j) >= idx) && (snap_num[4*j +: 4] != 4'h0)) upper_nz = 1'b1;
        end
    end

    assign blank_digit = snap_lz && (idx != '0) && !upper_nz;

    seven_seg_hex u_hex (
        .nyb (nyb),
        .seg (hex_seg)
    );

    // On-window length scales the usable (post-dead-time) slot in 16ths.
    assign presc_w = OW'(presc);
    assign on_len  = (SPAN_W * (OW'(bright_q) + OW'(1))) >> 4;
    assign lit     = (presc_w >= DEAD_W) && (presc_w < (DEAD_W + on_len));

    assign sel_on = ~(NUM_DIGITS'(1) << idx);
    assign seg_on = {~dp_bit, blank_digit ? 7'h7F : hex_seg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc      <= '0;
            idx        <= '0;
            bright_q   <= '0;
            snap_num   <= '0;
            snap_dp    <= '0;
            snap_lz    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= enable && frame_wrap;
            if (enable) begin
                presc <= slot_tick ? '0 : presc + 1'b1;
                if (slot_tick) begin
                    idx      <= frame_wrap ? '0 : idx + 1'b1;
                    bright_q <= brightness;
                    if (frame_wrap) begin
                        snap_num <= number;
                        snap_dp  <= dp;
                        snap_lz  <= blank_lz;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_sel <= '1;
            io_seg <= SEG_BLANK;
        end else if (enable && lit) begin
            io_sel <= sel_on;
            io_seg <= seg_on;
        end else begin
            io_sel <= '1;
            io_seg <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised scoreboard bench for display_scan_driver (4 digits, 32-cycle slots, 2 dead cycles).
module tb_display_scan_driver;

    localparam int ND = 4;
    localparam int RD = 32;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] number;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       ft;
        bit         lit;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: count of enabled cycles since reset, plus frame-level snapshot.
    int          n;
    logic [15:0] m_num;
    logic [3:0]  m_dp;
    bit          m_lz;
    int          m_br;

    display_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .number     (number),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .io_sel     (io_sel),
        .io_seg     (io_seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
            12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // Predict the outputs after the next rising edge from the inputs now applied.
    task automatic step();
        exp_t        e;
        int          c, d, on_len, nv;
        logic [7:0]  g;
        logic [15:0] upper;
        bit          blank;
        e.sel = 4'hF; e.seg = 8'hFF; e.ft = 1'b0; e.lit = 1'b0;
        if (!rst) begin
            n = 0; m_num = '0; m_dp = '0; m_lz = 1'b0; m_br = 0;
        end else if (enable) begin
            c      = n % RD;
            d      = (n / RD) % ND;
            on_len = ((RD - DC) * (m_br + 1)) / 16;
            e.lit  = (c >= DC) && (c < DC + on_len);
            upper  = m_num >> (4 * d);
            nv     = int'(upper & 16'hF);
            blank  = m_lz && (d != 0) && (upper == 16'h0);
            g      = glyph(nv);
            if (e.lit) begin
                e.sel = ~(4'b0001 << d);
                e.seg = {~m_dp[d], blank ? 7'h7F : g[6:0]};
            end
            e.ft = (c == RD - 1) && (d == ND - 1);
            if (c == RD - 1) begin
                m_br = int'(brightness);
                if (d == ND - 1) begin
                    m_num = number; m_dp = dp; m_lz = blank_lz;
                end
            end
            n = n + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            step();
            @(negedge clk);
        end
    endtask

    // Monitor: one prediction is consumed per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (io_sel !== e.sel || frame_tick !== e.ft || (e.lit && io_seg !== e.seg)) begin
                    miscompares++;
                    $display("FAIL scan t=%0t sel got %b want %b, seg got %h want %h (lit=%0d), tick got %b want %b",
                             $time, io_sel, e.sel, io_seg, e.seg, e.lit, frame_tick, e.ft);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; enable = 1'b1; number = 16'h0; dp = 4'h0; blank_lz = 1'b0; brightness = 4'd15;
        cyc(3);
        rst = 1'b1; number = 16'h1234;
        cyc(3 * ND * RD);

        brightness = 4'd7;  cyc(ND * RD);
        brightness = 4'd0;  cyc(ND * RD + RD / 2 + 3);
        brightness = 4'd9;  cyc(ND * RD);
        brightness = 4'd15;

        number = 16'h0050; blank_lz = 1'b1; cyc(2 * ND * RD);
        number = 16'h0000;                  cyc(2 * ND * RD);

        blank_lz = 1'b0; number = 16'h1111; cyc(2 * ND * RD + RD + 10);
        number = 16'h2222;                  cyc(2 * ND * RD);

        dp = 4'b0100; cyc(2 * ND * RD);
        dp = 4'b0000;

        // Asynchronous reset between edges, in the middle of a slot.
        cyc(5 * RD + 7);
        #7;
        rst = 1'b0;
        #1;
        vectors++;
        if (io_sel !== 4'hF || io_seg !== 8'hFF || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset sel=%b seg=%h tick=%b want 1111/ff/0", io_sel, io_seg, frame_tick);
        end
        @(negedge clk);
        cyc(3);
        rst = 1'b1;
        cyc(ND * RD + 20);

        enable = 1'b0; cyc(10);
        enable = 1'b1; cyc(2 * ND * RD);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) number = 16'($urandom);
            if ($urandom_range(0, 29) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 39) == 0) brightness = 4'($urandom);
            enable = ($urandom_range(0, 24) != 0);
            cyc(1);
        end
        enable = 1'b1;
        cyc(4);

        @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
